// File: rtl/encoder_pkg.sv
// RV32I encoder shared definitions: op kinds, opcodes, funct fields, loader states.
// No logic of its own; latency and backpressure belong to the modules that import it.
// The range helper is a pure function, with no timing or flow-control effects.
package encoder_pkg;

    typedef enum logic [3:0] {
        OPK_ADD   = 4'd0,
        OPK_SUB   = 4'd1,
        OPK_OR    = 4'd2,
        OPK_AND   = 4'd3,
        OPK_ADDI  = 4'd4,
        OPK_ORI   = 4'd5,
        OPK_ANDI  = 4'd6,
        OPK_LW    = 4'd7,
        OPK_JALR  = 4'd8,
        OPK_SW    = 4'd9,
        OPK_BEQ   = 4'd10,
        OPK_JAL   = 4'd11,
        OPK_LUI   = 4'd12,
        OPK_AUIPC = 4'd13
    } opk_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } ldr_state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when v is representable as a two's-complement number of 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/rv32_encode.sv
// Combinational RV32I encoder: descriptor fields -> 32-bit word plus illegal flag.
// Zero latency, purely combinational.
// No flow control; the caller qualifies the result with its own handshake.
module rv32_encode
    import encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OPK_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OPK_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_OP};
            OPK_OR:   word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
            OPK_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OPK_ADDI: begin
                word    = {imm[11:0], rs1, F3_ADD, rd, OPC_IMM};
                illegal = !fits_signed(imm, 12);
            end
            OPK_ORI: begin
                word    = {imm[11:0], rs1, F3_OR, rd, OPC_IMM};
                illegal = !fits_signed(imm, 12);
            end
            OPK_ANDI: begin
                word    = {imm[11:0], rs1, F3_AND, rd, OPC_IMM};
                illegal = !fits_signed(imm, 12);
            end
            OPK_LW: begin
                word    = {imm[11:0], rs1, F3_WORD, rd, OPC_LOAD};
                illegal = !fits_signed(imm, 12);
            end
            OPK_JALR: begin
                word    = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
                illegal = !fits_signed(imm, 12);
            end
            OPK_SW: begin
                word    = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
                illegal = !fits_signed(imm, 12);
            end
            // Branch and jump offsets are in bytes and must be halfword aligned.
            OPK_BEQ: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                illegal = !fits_signed(imm, 13) || imm[0];
            end
            OPK_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                illegal = !fits_signed(imm, 21) || imm[0];
            end
            OPK_LUI: begin
                word    = {imm[31:12], rd, OPC_LUI};
                illegal = (imm[11:0] != 12'd0);
            end
            OPK_AUIPC: begin
                word    = {imm[31:12], rd, OPC_AUIPC};
                illegal = (imm[11:0] != 12'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams micro-op descriptors into sequential RV32I words written to instruction memory.
// One register stage: a descriptor accepted at edge N drives imem_we from cycle N+1.
// in_ready drops while a write is pending and imem_ready is low; the write is held stable.
module instr_encoder_loader
    import encoder_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = encoder_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    ldr_state_e        state;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              in_fire;
    logic              wr_fire;

    rv32_encode u_enc (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // The output register may reload in the same cycle its current word drains.
    assign in_ready = (state == ST_LOAD) && (!imem_we || imem_ready);
    assign in_fire  = in_valid && in_ready;
    assign wr_fire  = imem_we && imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            next_addr  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            done <= 1'b0;
            if (wr_fire) begin
                word_count <= word_count + CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        busy       <= 1'b1;
                        next_addr  <= base_addr & ALIGN_MASK;
                        err        <= 1'b0;
                        err_count  <= '0;
                        word_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= next_addr;
                        imem_wdata <= enc_illegal ? NOP_WORD : enc_word;
                        next_addr  <= next_addr + ADDR_STEP;
                        if (enc_illegal) begin
                            err <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_ONE;
                            end
                        end
                        if (in_last) begin
                            state <= ST_DRAIN;
                        end
                    end else if (wr_fire) begin
                        imem_we <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (wr_fire) begin
                        imem_we <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
